// File: rtl/img_pkg.sv
// -----------------------------------------------------------------------------
// img_pkg
// Shared types and constants for the img_process pixel pipeline.
//   rgb555_t      : packed RGB555 pixel {r, g, b}, 5 bits per channel
//   IMG_*         : default line width / frame height of the VGA stream
//   GREY_*        : luminance weights (5/9/2) and the normalising shift (4)
//   rgb_to_grey() : 5-bit luminance from an RGB555 pixel
// -----------------------------------------------------------------------------
package img_pkg;

    typedef struct packed {
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
    } rgb555_t;

    localparam int IMG_LINE_WIDTH   = 800;
    localparam int IMG_FRAME_HEIGHT = 525;

    localparam int GREY_COEF_R = 5;
    localparam int GREY_COEF_G = 9;
    localparam int GREY_COEF_B = 2;
    localparam int GREY_SHIFT  = 4;

    // Weights sum to 16, so the worst case 16*31 = 496 fits in 9 bits.
    function automatic logic [4:0] rgb_to_grey(input rgb555_t px);
        logic [8:0] acc;
        acc = 9'(px.r) * 9'(GREY_COEF_R)
            + 9'(px.g) * 9'(GREY_COEF_G)
            + 9'(px.b) * 9'(GREY_COEF_B);
        return 5'(acc >> GREY_SHIFT);
    endfunction

endpackage

// File: rtl/img_line_buffer.sv
// -----------------------------------------------------------------------------
// img_line_buffer
// Two LINE_WIDTH x 5-bit line memories forming a 2-line shift buffer.
// Both lines are read combinationally at i_idx (old contents) and, on a write
// edge, line1[idx] takes line0[idx] while line0[idx] takes i_data.
// Contents are never reset; the consumer masks borders instead.
//   i_clk     : clock
//   i_wr_en   : shift/write enable at i_idx
//   i_idx     : shared column index (read and write)
//   i_data    : new 5-bit sample for line0
//   o_line0   : sample one line back (row-1)
//   o_line1   : sample two lines back (row-2)
// -----------------------------------------------------------------------------
module img_line_buffer #(
    parameter int LINE_WIDTH = 800
) (
    input  logic                          i_clk,
    input  logic                          i_wr_en,
    input  logic [$clog2(LINE_WIDTH)-1:0] i_idx,
    input  logic [4:0]                    i_data,
    output logic [4:0]                    o_line0,
    output logic [4:0]                    o_line1
);

    logic [4:0] r_line0 [LINE_WIDTH];
    logic [4:0] r_line1 [LINE_WIDTH];

    assign o_line0 = r_line0[i_idx];
    assign o_line1 = r_line1[i_idx];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_line1[i_idx] <= r_line0[i_idx];
            r_line0[i_idx] <= i_data;
        end
    end

endmodule

// File: rtl/img_process.sv
// -----------------------------------------------------------------------------
// img_process
// Streaming RGB555 -> 5-bit luminance -> 3x3 Sobel edge magnitude -> grey
// RGB555. One pixel is accepted per clock where i_is_new_read is high; the
// output is registered on that same edge and describes the window whose
// newest column holds the accepted pixel (centre one line + one pixel back).
//   i_clk          : clock
//   i_rst_n        : synchronous reset, active HIGH despite the name
//   i_is_new_read  : pixel-valid strobe
//   i_data         : pixel {R[14:10], G[9:5], B[4:0]}
//   o_data         : edge strength as {E, E, E}
// -----------------------------------------------------------------------------
module img_process
    import img_pkg::*;
#(
    parameter int LINE_WIDTH   = IMG_LINE_WIDTH,
    parameter int FRAME_HEIGHT = IMG_FRAME_HEIGHT,
    parameter int MAG_SHIFT    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_is_new_read,
    input  logic [14:0] i_data,
    output logic [14:0] o_data
);

    localparam int COL_W = $clog2(LINE_WIDTH);
    localparam int ROW_W = $clog2(FRAME_HEIGHT);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [4:0]       r_win  [3][3];   // [row: 0=top/oldest][col: 0=left/oldest]
    logic [4:0]       w_nwin [3][3];
    logic [4:0]       w_grey;
    logic [4:0]       w_line0;
    logic [4:0]       w_line1;
    logic [4:0]       w_edge;
    logic             w_border;
    logic             w_buf_wr;

    function automatic logic signed [9:0] ext(input logic [4:0] v);
        return signed'({5'b0, v});
    endfunction

    function automatic logic [9:0] abs_val(input logic signed [9:0] v);
        logic signed [9:0] n;
        n = (v < 0) ? -v : v;
        return $unsigned(n);
    endfunction

    function automatic logic [4:0] sat_edge(input logic [9:0] mag);
        logic [9:0] s;
        s = mag >> MAG_SHIFT;
        return (s > 10'd31) ? 5'd31 : s[4:0];
    endfunction

    function automatic logic [4:0] sobel_edge(
        input logic [4:0] tl, input logic [4:0] tm, input logic [4:0] tr,
        input logic [4:0] ml, input logic [4:0] mr,
        input logic [4:0] bl, input logic [4:0] bm, input logic [4:0] br
    );
        logic signed [9:0] gx;
        logic signed [9:0] gy;
        gx = (ext(tr) + (ext(mr) <<< 1) + ext(br)) - (ext(tl) + (ext(ml) <<< 1) + ext(bl));
        gy = (ext(bl) + (ext(bm) <<< 1) + ext(br)) - (ext(tl) + (ext(tm) <<< 1) + ext(tr));
        return sat_edge(abs_val(gx) + abs_val(gy));
    endfunction

    // ---- Stage: grey conversion and line-buffer column fetch ----
    assign w_grey   = rgb_to_grey(rgb555_t'(i_data));
    // A pixel presented during reset is discarded, so it must not shift the lines.
    assign w_buf_wr = i_is_new_read & ~i_rst_n;

    img_line_buffer #(
        .LINE_WIDTH (LINE_WIDTH)
    ) u_line_buffer (
        .i_clk   (i_clk),
        .i_wr_en (w_buf_wr),
        .i_idx   (r_col),
        .i_data  (w_grey),
        .o_line0 (w_line0),
        .o_line1 (w_line1)
    );

    // Window as it will look after this pixel: shift left, new column on the right.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_nwin[r][0] = r_win[r][1];
            w_nwin[r][1] = r_win[r][2];
        end
        w_nwin[0][2] = w_line1;
        w_nwin[1][2] = w_line0;
        w_nwin[2][2] = w_grey;
    end

    assign w_edge = sobel_edge(w_nwin[0][0], w_nwin[0][1], w_nwin[0][2],
                               w_nwin[1][0],               w_nwin[1][2],
                               w_nwin[2][0], w_nwin[2][1], w_nwin[2][2]);

    // Window not yet fully inside the current frame/line (incl. wrap-around).
    assign w_border = (r_row < ROW_W'(2)) || (r_col < COL_W'(2));

    // ---- Stage: window, counters and registered output ----
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            o_data <= '0;
            r_col  <= '0;
            r_row  <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (i_is_new_read) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= w_nwin[r][c];
                end
            end
            o_data <= w_border ? 15'h0000 : {w_edge, w_edge, w_edge};
            if (r_col == COL_W'(LINE_WIDTH - 1)) begin
                r_col <= '0;
                if (r_row == ROW_W'(FRAME_HEIGHT - 1)) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_img_process.sv
// -----------------------------------------------------------------------------
// tb_img_process
// Bench for img_process with a reduced image geometry (32 x 10) so whole
// frames fit in a short run. A frame-image reference model recomputes the
// Sobel edge from the stored luminance picture.
// -----------------------------------------------------------------------------
module tb_img_process;

    localparam int LW = 32;
    localparam int FH = 10;
    localparam int SH = 2;

    logic        clk;
    logic        i_rst_n;
    logic        i_is_new_read;
    logic [14:0] i_data;
    logic [14:0] o_data;

    int checks = 0;
    int errors = 0;

    // Reference model state: picture of the current frame and stream position.
    int          img [FH][LW];
    int          mrow;
    int          mcol;
    logic [14:0] exp_o;

    img_process #(
        .LINE_WIDTH   (LW),
        .FRAME_HEIGHT (FH),
        .MAG_SHIFT    (SH)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
        .i_is_new_read (i_is_new_read),
        .i_data        (i_data),
        .o_data        (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_grey(input logic [14:0] d);
        return (5 * int'(d[14:10]) + 9 * int'(d[9:5]) + 2 * int'(d[4:0])) / 16;
    endfunction

    // Edge value for the 3x3 neighbourhood whose bottom-right pixel is (r, c).
    function automatic int model_edge(input int r, input int c);
        int wt[3] = '{1, 2, 1};
        int gx, gy, mag;
        gx = 0;
        gy = 0;
        for (int i = 0; i < 3; i++) begin
            gx += wt[i] * (img[r-2+i][c] - img[r-2+i][c-2]);
            gy += wt[i] * (img[r][c-2+i] - img[r-2][c-2+i]);
        end
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        mag = mag >> SH;
        return (mag > 31) ? 31 : mag;
    endfunction

    function automatic logic [14:0] grey3(input int v);
        logic [4:0] e;
        e = 5'(v);
        return {e, e, e};
    endfunction

    // Drive one clock and advance the model accordingly.
    task automatic drive(input logic rst, input logic vld, input logic [14:0] d);
        i_rst_n       = rst;
        i_is_new_read = vld;
        i_data        = d;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_o = 15'h0000;
            mrow  = 0;
            mcol  = 0;
        end else if (vld) begin
            img[mrow][mcol] = model_grey(d);
            exp_o = (mrow < 2 || mcol < 2) ? 15'h0000 : grey3(model_edge(mrow, mcol));
            if (mcol == LW - 1) begin
                mcol = 0;
                mrow = (mrow == FH - 1) ? 0 : mrow + 1;
            end else begin
                mcol = mcol + 1;
            end
        end
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 15'(($urandom)));
        drive(1'b1, 1'b0, 15'h0000);
    endtask

    function automatic logic [14:0] edge_pixel(input int c);
        return (c >= LW / 2) ? 15'h7FFF : 15'h0000;
    endfunction

    function automatic logic [14:0] ramp_pixel(input int n);
        logic [4:0] v;
        v = 5'(n % 32);
        return {v, v, v};
    endfunction

    task automatic test_reset();
        drive(1'b1, 1'b1, 15'h7FFF);
        drive(1'b1, 1'b1, 15'h1234);
        checks++;
        if (o_data !== 15'h0000) begin
            errors++;
            $display("FAIL reset_out: got %h want %h", o_data, 15'h0000);
        end
        drive(1'b0, 1'b1, 15'h7FFF);
        checks++;
        if (o_data !== 15'h0000) begin
            errors++;
            $display("FAIL first_pixel: got %h want %h", o_data, 15'h0000);
        end
        // Random pixels into the interior: a pixel leaked from reset would shift everything.
        for (int k = 0; k < 3 * LW; k++) begin
            drive(1'b0, 1'b1, 15'($urandom));
            checks++;
            if (o_data !== exp_o) begin
                errors++;
                $display("FAIL reset_follow k=%0d: got %h want %h", k, o_data, exp_o);
            end
        end
    endtask

    task automatic test_flat();
        do_reset();
        for (int k = 0; k < LW * FH; k++) begin
            drive(1'b0, 1'b1, 15'h4210);
            checks++;
            if (o_data !== 15'h0000 || o_data !== exp_o) begin
                errors++;
                $display("FAIL flat k=%0d: got %h want %h", k, o_data, 15'h0000);
            end
        end
    endtask

    task automatic test_edge();
        int r0, c0;
        logic [14:0] want;
        do_reset();
        for (int k = 0; k < LW * FH; k++) begin
            r0 = mrow;
            c0 = mcol;
            drive(1'b0, 1'b1, edge_pixel(c0));
            want = (r0 >= 2 && (c0 == LW / 2 || c0 == LW / 2 + 1)) ? 15'h7FFF : 15'h0000;
            checks++;
            if (o_data !== want || o_data !== exp_o) begin
                errors++;
                $display("FAIL edge r=%0d c=%0d: got %h want %h", r0, c0, o_data, want);
            end
        end
    endtask

    task automatic test_ramp();
        int r0, c0, n;
        do_reset();
        n = 7;
        for (int k = 0; k < 2 * LW * FH; k++) begin
            r0 = mrow;
            c0 = mcol;
            drive(1'b0, 1'b1, ramp_pixel(n));
            checks++;
            if (o_data !== exp_o) begin
                errors++;
                $display("FAIL ramp r=%0d c=%0d: got %h want %h", r0, c0, o_data, exp_o);
            end
            // Interior windows whose values do not cross the 31->0 wrap: Gx=8 -> E=2.
            if (r0 >= 2 && c0 >= 2 && (n % 32) >= 2) begin
                checks++;
                if (o_data !== 15'h0842) begin
                    errors++;
                    $display("FAIL ramp_const r=%0d c=%0d: got %h want %h", r0, c0, o_data, 15'h0842);
                end
            end
            n++;
        end
    endtask

    task automatic test_stall();
        int n;
        logic [14:0] held;
        do_reset();
        n = 3;
        for (int k = 0; k < 3 * LW + 10; k++) begin
            drive(1'b0, 1'b1, ramp_pixel(n));
            n++;
        end
        held = exp_o;
        for (int s = 0; s < 10; s++) begin
            drive(1'b0, 1'b0, 15'($urandom));
            checks++;
            if (o_data !== held) begin
                errors++;
                $display("FAIL stall_hold s=%0d: got %h want %h", s, o_data, held);
            end
        end
        // Counters and window must have held: continuation matches an unstalled run.
        for (int k = 0; k < 2 * LW; k++) begin
            drive(1'b0, 1'b1, ramp_pixel(n));
            n++;
            checks++;
            if (o_data !== exp_o) begin
                errors++;
                $display("FAIL stall_resume k=%0d: got %h want %h", k, o_data, exp_o);
            end
        end
        for (int k = 0; k < LW + 5; k++) begin
            drive(1'b0, 1'b1, edge_pixel(mcol));
        end
        held = exp_o;
        for (int s = 0; s < 10; s++) begin
            drive(1'b0, 1'b0, 15'h7FFF);
            checks++;
            if (o_data !== held) begin
                errors++;
                $display("FAIL stall_edge_hold s=%0d: got %h want %h", s, o_data, held);
            end
        end
        for (int k = 0; k < 2 * LW; k++) begin
            drive(1'b0, 1'b1, edge_pixel(mcol));
            checks++;
            if (o_data !== exp_o) begin
                errors++;
                $display("FAIL stall_edge_resume k=%0d: got %h want %h", k, o_data, exp_o);
            end
        end
    endtask

    task automatic test_midframe_reset();
        int r0, c0;
        logic [14:0] want;
        do_reset();
        for (int k = 0; k < 6 * LW + 10; k++) begin
            drive(1'b0, 1'b1, edge_pixel(mcol));
        end
        // Reset with a valid pixel present: the pixel is discarded.
        drive(1'b1, 1'b1, 15'h7FFF);
        checks++;
        if (o_data !== 15'h0000) begin
            errors++;
            $display("FAIL midreset_out: got %h want %h", o_data, 15'h0000);
        end
        for (int k = 0; k < LW * FH; k++) begin
            r0 = mrow;
            c0 = mcol;
            drive(1'b0, 1'b1, edge_pixel(c0));
            want = (r0 >= 2 && (c0 == LW / 2 || c0 == LW / 2 + 1)) ? 15'h7FFF : 15'h0000;
            checks++;
            if (o_data !== want) begin
                errors++;
                $display("FAIL midreset_edge r=%0d c=%0d: got %h want %h", r0, c0, o_data, want);
            end
        end
    endtask

    task automatic test_random();
        logic rst, vld;
        do_reset();
        for (int k = 0; k < 3 * LW * FH; k++) begin
            rst = ($urandom_range(0, 499) == 0);
            vld = ($urandom_range(0, 3) != 0);
            drive(rst, vld, 15'($urandom));
            checks++;
            if (o_data !== exp_o) begin
                errors++;
                $display("FAIL random k=%0d r=%0d c=%0d: got %h want %h", k, mrow, mcol, o_data, exp_o);
            end
        end
    endtask

    initial begin
        i_rst_n       = 1'b1;
        i_is_new_read = 1'b0;
        i_data        = 15'h0000;
        mrow          = 0;
        mcol          = 0;
        exp_o         = 15'h0000;
        for (int r = 0; r < FH; r++) begin
            for (int c = 0; c < LW; c++) begin
                img[r][c] = 0;
            end
        end
        test_reset();
        test_flat();
        test_edge();
        test_ramp();
        test_stall();
        test_midframe_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
